// File: rtl/game_timer_pkg.sv
// Shared types for the game timer: controller state and count direction.
package game_timer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        PAUSED  = 2'd2,
        EXPIRED = 2'd3
    } state_e;

    typedef enum logic {
        MODE_DOWN = 1'b0,
        MODE_UP   = 1'b1
    } mode_e;

endpackage

// File: rtl/game_timer_tick_prescaler.sv
// Divides the clock into one-cycle time-unit ticks; holds its count while disabled.
module tick_prescaler #(
    parameter int CYCLES_PER_TICK = 100_000_000
) (
    input  logic clk_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic tick_o
);

    localparam int CW = (CYCLES_PER_TICK > 1) ? $clog2(CYCLES_PER_TICK) : 1;
    localparam logic [CW-1:0] LAST = CW'(CYCLES_PER_TICK - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick_o = enable_i && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = tick_o ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/game_timer.sv
// Run-time loadable game timer: countdown / stopwatch with pause, abort and bonus add.
module game_timer
    import game_timer_pkg::*;
#(
    parameter int CYCLES_PER_TICK = 100_000_000,
    parameter int TIME_WIDTH      = 10,
    parameter int DEFAULT_LOAD    = 60,
    parameter int WARN_THRESHOLD  = 10
) (
    input  logic                  clk_100mhz_in,
    input  logic                  rst_in,
    input  logic                  load_in,
    input  logic [TIME_WIDTH-1:0] load_value_in,
    input  logic                  mode_up_in,
    input  logic                  start_in,
    input  logic                  pause_in,
    input  logic                  stop_in,
    input  logic                  add_in,
    input  logic [TIME_WIDTH-1:0] add_value_in,
    output logic [TIME_WIDTH-1:0] time_out,
    output logic                  tick_out,
    output logic                  running_out,
    output logic                  paused_out,
    output logic                  warn_out,
    output logic                  done_out,
    output logic                  expired_out
);

    localparam logic [TIME_WIDTH-1:0] LOAD0 = TIME_WIDTH'(DEFAULT_LOAD);
    localparam logic [TIME_WIDTH:0]   MAXV  = {1'b0, {TIME_WIDTH{1'b1}}};
    localparam logic [TIME_WIDTH:0]   WARNV = (TIME_WIDTH + 1)'(WARN_THRESHOLD);

    state_e                state_q, state_d;
    mode_e                 mode_q, mode_d;
    logic [TIME_WIDTH-1:0] target_q, target_d;
    logic [TIME_WIDTH-1:0] time_q, time_d;
    logic                  tick_q, tick_d;
    logic                  done_q, done_d;

    logic                  psc_en;
    logic                  psc_clr;
    logic                  psc_tick;
    logic                  launch;
    logic [TIME_WIDTH:0]   base;
    logic [TIME_WIDTH:0]   sum;
    logic [TIME_WIDTH:0]   up_next;

    assign launch  = start_in && (state_q == IDLE || state_q == EXPIRED);
    assign psc_en  = (state_q == RUNNING) && !rst_in && !stop_in && !pause_in;
    assign psc_clr = rst_in || stop_in || launch;

    tick_prescaler #(
        .CYCLES_PER_TICK(CYCLES_PER_TICK)
    ) u_psc (
        .clk_i   (clk_100mhz_in),
        .clear_i (psc_clr),
        .enable_i(psc_en),
        .tick_o  (psc_tick)
    );

    always_ff @(posedge clk_100mhz_in) begin
        if (rst_in) begin
            state_q  <= IDLE;
            mode_q   <= MODE_DOWN;
            target_q <= LOAD0;
            time_q   <= LOAD0;
            tick_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            target_q <= target_d;
            time_q   <= time_d;
            tick_q   <= tick_d;
            done_q   <= done_d;
        end
    end

    // Tick and bonus are folded into one widened sum so saturation and expiry see the net result.
    always_comb begin
        base    = {1'b0, time_q};
        if (psc_tick && time_q != '0) begin
            base = {1'b0, time_q} - 1'b1;
        end
        sum     = base;
        if (add_in && mode_q == MODE_DOWN) begin
            sum = base + {1'b0, add_value_in};
        end
        up_next = {1'b0, time_q} + 1'b1;
    end

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        target_d = target_q;
        time_d   = time_q;
        tick_d   = 1'b0;
        done_d   = 1'b0;
        if (stop_in) begin
            state_d = IDLE;
            time_d  = target_q;
        end else begin
            case (state_q)
                IDLE, EXPIRED: begin
                    if (start_in) begin
                        mode_d = mode_up_in ? MODE_UP : MODE_DOWN;
                        if (target_q == '0) begin
                            state_d = EXPIRED;
                            time_d  = '0;
                            done_d  = 1'b1;
                        end else begin
                            state_d = RUNNING;
                            time_d  = mode_up_in ? '0 : target_q;
                        end
                    end else if (load_in) begin
                        state_d  = IDLE;
                        target_d = load_value_in;
                        time_d   = load_value_in;
                    end else if (state_q == IDLE) begin
                        time_d = target_q;
                    end
                end
                RUNNING: begin
                    if (pause_in) begin
                        state_d = PAUSED;
                    end else if (mode_q == MODE_DOWN) begin
                        tick_d = psc_tick;
                        time_d = (sum > MAXV) ? MAXV[TIME_WIDTH-1:0]
                                              : sum[TIME_WIDTH-1:0];
                        if (sum == '0) begin
                            state_d = EXPIRED;
                            done_d  = 1'b1;
                        end
                    end else if (psc_tick) begin
                        tick_d = 1'b1;
                        time_d = up_next[TIME_WIDTH-1:0];
                        if (up_next >= {1'b0, target_q}) begin
                            time_d  = target_q;
                            state_d = EXPIRED;
                            done_d  = 1'b1;
                        end
                    end
                end
                PAUSED: begin
                    if (start_in) begin
                        state_d = RUNNING;
                    end else if (add_in && mode_q == MODE_DOWN) begin
                        time_d = (sum > MAXV) ? MAXV[TIME_WIDTH-1:0]
                                              : sum[TIME_WIDTH-1:0];
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        time_out    = time_q;
        tick_out    = tick_q;
        done_out    = done_q;
        running_out = (state_q == RUNNING);
        paused_out  = (state_q == PAUSED);
        expired_out = (state_q == EXPIRED);
        warn_out    = (mode_q == MODE_DOWN)
                   && (state_q == RUNNING || state_q == PAUSED)
                   && (time_q != '0)
                   && ({1'b0, time_q} <= WARNV);
    end

endmodule

// File: tb/tb_game_timer.sv
// Directed bench for game_timer with CYCLES_PER_TICK=4.
module tb_game_timer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load = 1'b0;
    logic [9:0] load_val = '0;
    logic       mode_up = 1'b0;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic       stop = 1'b0;
    logic       add = 1'b0;
    logic [9:0] add_val = '0;
    logic [9:0] t;
    logic       tick, running, paused, warn, done, expired;

    int checks = 0;
    int failures = 0;
    int ticks_seen;

    game_timer #(
        .CYCLES_PER_TICK(4),
        .TIME_WIDTH(10),
        .DEFAULT_LOAD(60),
        .WARN_THRESHOLD(10)
    ) dut (
        .clk_100mhz_in(clk),
        .rst_in       (rst),
        .load_in      (load),
        .load_value_in(load_val),
        .mode_up_in   (mode_up),
        .start_in     (start),
        .pause_in     (pause),
        .stop_in      (stop),
        .add_in       (add),
        .add_value_in (add_val),
        .time_out     (t),
        .tick_out     (tick),
        .running_out  (running),
        .paused_out   (paused),
        .warn_out     (warn),
        .done_out     (done),
        .expired_out  (expired)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    task automatic edges(input int n);
        for (int i = 0; i < n; i++) edge1();
    endtask

    // flags packed as {tick,running,paused,warn,done,expired}
    function automatic int flags();
        return {26'd0, tick, running, paused, warn, done, expired};
    endfunction

    task automatic do_load(input int v);
        load = 1'b1;
        load_val = 10'(v);
        edge1();
        load = 1'b0;
    endtask

    task automatic do_start(input logic up);
        mode_up = up;
        start = 1'b1;
        edge1();
        start = 1'b0;
        mode_up = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        edge1();
        stop = 1'b0;
    endtask

    initial begin
        // reset
        edges(2);
        chk("rst_time", t, 60);
        chk("rst_flags", flags(), 0);
        rst = 1'b0;

        // countdown 3 -> 0
        do_load(3);
        chk("load3_time", t, 3);
        do_start(1'b0);
        chk("start3_time", t, 3);
        chk("start3_run", running, 1);
        ticks_seen = 0;
        for (int k = 1; k <= 12; k++) begin
            edge1();
            ticks_seen += tick;
            chk($sformatf("cd_time_k%0d", k), t, 3 - k / 4);
            chk($sformatf("cd_done_k%0d", k), done, (k == 12) ? 1 : 0);
            if (k == 1) chk("cd_warn", warn, 1);
        end
        chk("cd_ticks", ticks_seen, 3);
        chk("cd_expired", expired, 1);
        edge1();
        chk("cd_hold_flags", flags(), 1);
        chk("cd_hold_time", t, 0);

        // pause / resume, warn
        do_load(12);
        chk("load12_flags", flags(), 0);
        do_start(1'b0);
        edges(2);
        pause = 1'b1;
        edge1();
        pause = 1'b0;
        chk("pause_flags", flags(), 6'b001000);
        edges(20);
        chk("pause_hold_time", t, 12);
        chk("pause_hold_flags", flags(), 6'b001000);
        start = 1'b1;
        edge1();
        start = 1'b0;
        chk("resume_run", running, 1);
        edge1();
        chk("resume_p1_time", t, 12);
        edge1();
        chk("resume_p2_time", t, 11);
        chk("resume_p2_tick", tick, 1);
        edges(3);
        chk("pre_warn_time", t, 11);
        chk("pre_warn", warn, 0);
        edge1();
        chk("warn_time", t, 10);
        chk("warn_rise", warn, 1);
        pause = 1'b1;
        edge1();
        pause = 1'b0;
        edges(5);
        chk("warn_paused", flags(), 6'b001100);
        do_stop();
        chk("stop12_time", t, 12);
        chk("stop12_flags", flags(), 0);

        // saturating bonus with coincident tick
        do_load(5);
        do_start(1'b0);
        edges(3);
        add = 1'b1;
        add_val = 10'd1020;
        edge1();
        add = 1'b0;
        chk("sat_time", t, 1023);
        chk("sat_tick", tick, 1);
        do_stop();

        do_load(1);
        do_start(1'b0);
        edges(3);
        add = 1'b1;
        add_val = 10'd4;
        edge1();
        add = 1'b0;
        chk("rescue_time", t, 4);
        chk("rescue_flags", flags(), 6'b110100);
        do_stop();

        // count-up
        do_load(2);
        do_start(1'b1);
        chk("up_start_time", t, 0);
        edge1();
        add = 1'b1;
        add_val = 10'd5;
        edge1();
        add = 1'b0;
        chk("up_add_ignored", t, 0);
        chk("up_warn", warn, 0);
        edges(2);
        chk("up_t1", t, 1);
        chk("up_t1_tick", tick, 1);
        edges(3);
        chk("up_t1_warn", warn, 0);
        edge1();
        chk("up_t2", t, 2);
        chk("up_done_flags", flags(), 6'b100011);
        edge1();
        chk("up_after_flags", flags(), 1);

        // zero target
        do_load(0);
        do_start(1'b0);
        chk("zero_flags", flags(), 6'b000011);
        chk("zero_time", t, 0);
        edge1();
        chk("zero_after", flags(), 1);

        // stop mid-run at 7
        do_load(9);
        do_start(1'b0);
        edges(8);
        chk("mid_time", t, 7);
        do_stop();
        chk("mid_stop_time", t, 9);
        chk("mid_stop_flags", flags(), 0);

        // reset with tick pending
        do_start(1'b0);
        edges(3);
        rst = 1'b1;
        edge1();
        rst = 1'b0;
        chk("rst_mid_time", t, 60);
        chk("rst_mid_flags", flags(), 0);
        edge1();
        chk("rst_mid_idle", flags(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/game_timer.md
Name: game_timer

Overview:
- Parametrised run-time-loadable game timer; successor to the fixed 60 s countdown.
- Adds count-down and count-up (stopwatch) modes, pause/resume, abort, and bonus-time add.
- Adds a per-tick strobe, a low-time warning flag, and a one-cycle expiry pulse.
- Sits between game-control FSM and HUD/renderer; time_out feeds the on-screen digit display.

Parameters:
- CYCLES_PER_TICK, 100_000_000, clock cycles per time unit (1 s at 100 MHz); benches use 4.
- TIME_WIDTH, 10, width of time value and target.
- DEFAULT_LOAD, 60, reset value of the target register and of time_out.
- WARN_THRESHOLD, 10, warn_out asserted when the countdown value is at or below this.

Ports:
- clk_100mhz_in  in  1  system clock.
- rst_in  in  1  synchronous, active-high reset.
- load_in  in  1  pulse; latch load_value_in into target (IDLE/EXPIRED only).
- load_value_in  in  TIME_WIDTH  new target value.
- mode_up_in  in  1  0 = countdown, 1 = count-up; sampled only on start.
- start_in  in  1  pulse; start from IDLE/EXPIRED, resume from PAUSED.
- pause_in  in  1  pulse; RUNNING -> PAUSED.
- stop_in  in  1  pulse; abort to IDLE from any state.
- add_in  in  1  pulse; add add_value_in to time (countdown, RUNNING/PAUSED only).
- add_value_in  in  TIME_WIDTH  bonus amount.
- time_out  out  TIME_WIDTH  current time value.
- tick_out  out  1  one-cycle pulse per elapsed time unit.
- running_out  out  1  state == RUNNING.
- paused_out  out  1  state == PAUSED.
- warn_out  out  1  low-time warning.
- done_out  out  1  one-cycle expiry pulse.
- expired_out  out  1  state == EXPIRED.

Behaviour:
- Reset: state IDLE; target = DEFAULT_LOAD; time_out = DEFAULT_LOAD; prescaler = 0; mode = down; all 1-bit outputs 0.
- Input priority: rst_in > stop_in > start_in/pause_in > add_in/tick.

IDLE:
- time_out tracks target.
- load_in sets target and time_out to load_value_in on the next cycle.
- On start_in:
  - prescaler cleared; mode latched from mode_up_in.
  - time_out = target (down) or 0 (up).
  - State -> RUNNING.
  - If the latched start value already equals the expiry value (down with target 0, or up with target 0): -> EXPIRED instead, done_out pulses on that cycle.

RUNNING:
- Prescaler increments each cycle.
- At CYCLES_PER_TICK-1: prescaler wraps to 0, tick_out pulses, time_out decrements (down) or increments (up) on the same edge.
- Down expiry: tick taking time_out 1 -> 0 moves to EXPIRED. done_out is high in the first cycle time_out reads 0.
- Up expiry: tick making time_out == target moves to EXPIRED, same done_out timing.
- pause_in -> PAUSED. Prescaler value is held, not cleared, so resume continues the partial unit.
- A tick coinciding with pause_in is suppressed; the prescaler stays at its current value.

PAUSED:
- No prescaler advance, no tick_out.
- start_in -> RUNNING.
- add_in honoured.

add_in (down mode, RUNNING/PAUSED):
- time_out += add_value_in, saturating at 2^TIME_WIDTH-1.
- With a simultaneous tick: result = sat(time_out - 1 + add_value_in), and expiry is evaluated on that result.
- Ignored in up mode and in IDLE/EXPIRED.

EXPIRED:
- time_out holds its final value; expired_out is high.
- load_in updates target and time_out, state -> IDLE.
- start_in restarts exactly as from IDLE.

stop_in:
- Any state -> IDLE; time_out = target; prescaler = 0; no done_out.

warn_out:
- Combinational from registered state/time_out.
- High when mode is down, state is RUNNING or PAUSED, and 0 < time_out <= WARN_THRESHOLD.

Arithmetic:
- Prescaler width $clog2(CYCLES_PER_TICK).
- Comparisons are performed at TIME_WIDTH+1 bits to avoid wrap.
- The up count never exceeds target.

Decomposition:
- Package game_timer_pkg: state enum (IDLE, RUNNING, PAUSED, EXPIRED), mode enum (MODE_DOWN, MODE_UP).
- Sub-module tick_prescaler:
  - Parameter CYCLES_PER_TICK; inputs enable and clear; output tick pulse.
  - Holds its count when enable is low.

Test Plan (CYCLES_PER_TICK=4, TIME_WIDTH=10, DEFAULT_LOAD=60, WARN_THRESHOLD=10):
- Reset then load 3, start, down mode: time_out is 3, 2, 1, 0 at 4-cycle spacing. tick_out pulses 3 times. done_out is one cycle, coincident with the first 0. expired_out then stays high.
- Load 12, start, pause after 2 cycles, hold 20 cycles, resume: first decrement lands exactly 2 cycles after resume. warn_out rises when time_out reaches 10 and stays high while paused.
- Down at time 5, add 1020 on the same cycle as a tick: time_out = 1023 (saturated). Separately, at time 1 with add 4 coinciding with a tick: time_out = 4, no expiry.
- mode_up_in=1, target 2, start: time_out 0 -> 1 -> 2, done_out pulses at 2. warn_out never asserts. add_in is ignored.
- Start with target 0 (down): EXPIRED with done_out on the next cycle and no tick_out. stop_in mid-run at time 7 (target 9): IDLE, time_out = 9, no done_out.
- rst_in asserted mid-RUNNING with a tick pending: next cycle time_out = 60, all flags 0, no tick_out or done_out.
